// File: rtl/char_action_pkg.sv
// Shared state encodings, widths and default phase lengths for the character action FSM.
package char_action_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 4'd0,
    ST_LEFT       = 4'd1,
    ST_RIGHT      = 4'd2,
    ST_ATK_START  = 4'd3,
    ST_ATK_ACTIVE = 4'd4,
    ST_ATK_REC    = 4'd5,
    ST_DIR_START  = 4'd6,
    ST_DIR_ACTIVE = 4'd7,
    ST_DIR_REC    = 4'd8,
    ST_HITSTUN    = 4'd9,
    ST_BLOCKSTUN  = 4'd10
  } state_t;

  localparam int unsigned DEF_CNT_W        = 5;
  localparam int unsigned DEF_ATK_START_F  = 5;
  localparam int unsigned DEF_ATK_ACTIVE_F = 2;
  localparam int unsigned DEF_ATK_REC_F    = 16;
  localparam int unsigned DEF_DIR_START_F  = 4;
  localparam int unsigned DEF_DIR_ACTIVE_F = 3;
  localparam int unsigned DEF_DIR_REC_F    = 15;
  localparam int unsigned DEF_BUF_F        = 3;

endpackage

// File: rtl/char_action_fsm_if.sv
// Key/stun inputs and state outputs of one character action FSM.
interface char_action_fsm_if #(
  parameter int unsigned CNT_W = 5
);
  import char_action_pkg::*;

  logic               ENABLE;
  logic               FRAME_TICK;
  logic               CHAR_NO;
  logic               KEY_LEFT;
  logic               KEY_RIGHT;
  logic               KEY_ATTACK;
  logic               STUN_REQ;
  logic [CNT_W-1:0]   STUN_FRAMES;
  logic               STUN_BLOCK;
  logic [STATE_W-1:0] STATE;
  logic [CNT_W-1:0]   FrameCounter;
  logic               BLOCK_FLAG;
  logic               HIT_ACTIVE;
  logic               BUF_PENDING;

  modport master (
    output ENABLE, FRAME_TICK, CHAR_NO, KEY_LEFT, KEY_RIGHT, KEY_ATTACK,
    output STUN_REQ, STUN_FRAMES, STUN_BLOCK,
    input  STATE, FrameCounter, BLOCK_FLAG, HIT_ACTIVE, BUF_PENDING
  );

  modport slave (
    input  ENABLE, FRAME_TICK, CHAR_NO, KEY_LEFT, KEY_RIGHT, KEY_ATTACK,
    input  STUN_REQ, STUN_FRAMES, STUN_BLOCK,
    output STATE, FrameCounter, BLOCK_FLAG, HIT_ACTIVE, BUF_PENDING
  );

endinterface

// File: rtl/char_stun_latch.sv
// Holds a pending stun request until the next enabled frame tick applies it.
module char_stun_latch #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             tick,
  input  logic             stun_req,
  input  logic [CNT_W-1:0] stun_frames,
  input  logic             stun_block,
  output logic             pend_c,
  output logic [CNT_W-1:0] frames_c,
  output logic             block_c
);

  logic             pend_q;
  logic [CNT_W-1:0] frames_q;
  logic             block_q;
  logic             req_ok_c;

  // Zero-length requests are dropped; a live request also bypasses the latch so a same-cycle tick sees it.
  assign req_ok_c = stun_req && (stun_frames != '0);
  assign pend_c   = pend_q | req_ok_c;
  assign frames_c = req_ok_c ? stun_frames : frames_q;
  assign block_c  = req_ok_c ? stun_block  : block_q;

  // Capture/overwrite on request; any enabled tick consumes the latch, ENABLE low flushes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= 1'b0;
      frames_q <= '0;
      block_q  <= 1'b0;
    end else if (!enable || tick) begin
      pend_q   <= 1'b0;
    end else if (req_ok_c) begin
      pend_q   <= 1'b1;
      frames_q <= stun_frames;
      block_q  <= stun_block;
    end
  end

endmodule

// File: rtl/char_action_fsm.sv
// Per-character movement / attack / stun state machine, timed in game frames.
module char_action_fsm
  import char_action_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned ATK_START_F  = DEF_ATK_START_F,
  parameter int unsigned ATK_ACTIVE_F = DEF_ATK_ACTIVE_F,
  parameter int unsigned ATK_REC_F    = DEF_ATK_REC_F,
  parameter int unsigned DIR_START_F  = DEF_DIR_START_F,
  parameter int unsigned DIR_ACTIVE_F = DEF_DIR_ACTIVE_F,
  parameter int unsigned DIR_REC_F    = DEF_DIR_REC_F,
  parameter int unsigned BUF_F        = DEF_BUF_F
) (
  input logic CLOCK,
  input logic RESET_N,
  char_action_fsm_if.slave bus
);

  localparam int unsigned CNT_MAX = (32'(1) << CNT_W) - 1;

  // Every phase must fit the counter and last at least one frame.
  if (ATK_START_F < 1 || ATK_START_F > CNT_MAX || ATK_ACTIVE_F < 1 || ATK_ACTIVE_F > CNT_MAX ||
      ATK_REC_F   < 1 || ATK_REC_F   > CNT_MAX || DIR_START_F  < 1 || DIR_START_F  > CNT_MAX ||
      DIR_ACTIVE_F < 1 || DIR_ACTIVE_F > CNT_MAX || DIR_REC_F  < 1 || DIR_REC_F    > CNT_MAX) begin : g_param_err
    $error("char_action_fsm: phase length outside 1..2^CNT_W-1");
  end

  state_t           state_q;
  state_t           next_c;
  logic [CNT_W-1:0] cnt_q;
  logic             buf_q;
  logic             rec_c;
  logic             buf_set_c;
  logic             buf_hit_c;
  logic             stun_pend_c;
  logic [CNT_W-1:0] stun_frames_c;
  logic             stun_block_c;
  logic             any_dir_c;

  char_stun_latch #(.CNT_W(CNT_W)) u_stun (
    .clk         (CLOCK),
    .rst_n       (RESET_N),
    .enable      (bus.ENABLE),
    .tick        (bus.FRAME_TICK),
    .stun_req    (bus.STUN_REQ),
    .stun_frames (bus.STUN_FRAMES),
    .stun_block  (bus.STUN_BLOCK),
    .pend_c      (stun_pend_c),
    .frames_c    (stun_frames_c),
    .block_c     (stun_block_c)
  );

  // Frame count loaded on entry to a state; untimed states park the counter at zero.
  function automatic logic [CNT_W-1:0] phase_len(input state_t s);
    case (s)
      ST_ATK_START:  phase_len = CNT_W'(ATK_START_F);
      ST_ATK_ACTIVE: phase_len = CNT_W'(ATK_ACTIVE_F);
      ST_ATK_REC:    phase_len = CNT_W'(ATK_REC_F);
      ST_DIR_START:  phase_len = CNT_W'(DIR_START_F);
      ST_DIR_ACTIVE: phase_len = CNT_W'(DIR_ACTIVE_F);
      ST_DIR_REC:    phase_len = CNT_W'(DIR_REC_F);
      default:       phase_len = '0;
    endcase
  endfunction

  assign any_dir_c = bus.KEY_LEFT | bus.KEY_RIGHT;
  assign rec_c     = (state_q == ST_ATK_REC) || (state_q == ST_DIR_REC);
  assign buf_set_c = rec_c && bus.KEY_ATTACK && (32'(cnt_q) <= BUF_F);
  assign buf_hit_c = buf_q | buf_set_c;

  // Key decode for untimed states and exit target for timed states.
  always_comb begin
    next_c = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (bus.KEY_ATTACK)     next_c = any_dir_c ? ST_DIR_START : ST_ATK_START;
        else if (bus.KEY_LEFT)  next_c = ST_LEFT;
        else if (bus.KEY_RIGHT) next_c = ST_RIGHT;
      end
      ST_LEFT, ST_RIGHT: begin
        if (bus.KEY_ATTACK)     next_c = ST_DIR_START;
        else if (bus.KEY_RIGHT) next_c = ST_RIGHT;
        else if (bus.KEY_LEFT)  next_c = ST_LEFT;
      end
      ST_ATK_START:  next_c = ST_ATK_ACTIVE;
      ST_ATK_ACTIVE: next_c = ST_ATK_REC;
      ST_DIR_START:  next_c = ST_DIR_ACTIVE;
      ST_DIR_ACTIVE: next_c = ST_DIR_REC;
      ST_ATK_REC, ST_DIR_REC: begin
        if (buf_hit_c) next_c = any_dir_c ? ST_DIR_START : ST_ATK_START;
      end
      default: next_c = ST_IDLE;
    endcase
  end

  // State, frame counter and attack buffer; only enabled frame ticks advance them.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= 1'b0;
    end else if (!bus.ENABLE) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= 1'b0;
    end else if (bus.FRAME_TICK) begin
      if (stun_pend_c) begin
        state_q <= stun_block_c ? ST_BLOCKSTUN : ST_HITSTUN;
        cnt_q   <= stun_frames_c;
        buf_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_LEFT, ST_RIGHT: begin
            state_q <= next_c;
            cnt_q   <= phase_len(next_c);
          end
          ST_ATK_START, ST_ATK_ACTIVE, ST_ATK_REC, ST_DIR_START,
          ST_DIR_ACTIVE, ST_DIR_REC, ST_HITSTUN, ST_BLOCKSTUN: begin
            if (cnt_q > CNT_W'(1)) begin
              cnt_q <= cnt_q - CNT_W'(1);
              if (buf_set_c) buf_q <= 1'b1;
            end else begin
              state_q <= next_c;
              cnt_q   <= phase_len(next_c);
              buf_q   <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            buf_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.STATE        = state_q;
  assign bus.FrameCounter = cnt_q;
  assign bus.BUF_PENDING  = buf_q;
  assign bus.BLOCK_FLAG   = (!bus.CHAR_NO && (state_q == ST_LEFT)) || (bus.CHAR_NO && (state_q == ST_RIGHT));
  assign bus.HIT_ACTIVE   = (state_q == ST_ATK_ACTIVE) || (state_q == ST_DIR_ACTIVE);

endmodule
